// File: rtl/m_layer_1_pool_reader.sv
// Layer-1 pooling reader: walks the written feature map in 2x2 windows,
// takes the unsigned max of each and streams the pooled pixels out.
module m_layer_1_pool_reader #(
    parameter int IMG_W  = 26,
    parameter int IMG_H  = 26,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int POUT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_1_write_complete,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] ram_d,
    output logic [DATA_W-1:0] pool_d,
    output logic [POUT_W-1:0] pool_addr,
    output logic              pool_valid,
    input  logic              pool_ready,
    output logic              pool_complete
);

    localparam int OW = IMG_W / 2;
    localparam int OH = IMG_H / 2;
    localparam int CW = (OW > 1) ? $clog2(OW) : 1;
    localparam int RW = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [CW-1:0]     C_LAST   = CW'(OW - 1);
    localparam logic [RW-1:0]     R_LAST   = RW'(OH - 1);
    localparam logic [ADDR_W-1:0] ROW_OFF  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W + 2);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_OUT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [1:0]        k;
    logic [CW-1:0]     c;
    logic [RW-1:0]     r;
    logic [ADDR_W-1:0] base;
    logic [POUT_W-1:0] pidx;
    logic [DATA_W-1:0] max_q;

    logic start;
    logic accept;
    logic last_win;
    logic capture;

    assign start    = (state == S_IDLE) && layer_1_write_complete;
    assign accept   = (state == S_OUT) && pool_ready;
    assign last_win = (r == R_LAST) && (c == C_LAST);
    // datum for fetch k arrives during cycle k+1 (or LAST for k=3)
    assign capture  = ((state == S_FETCH) && (k != 2'd0)) || (state == S_LAST);

    assign pool_d    = max_q;
    assign pool_addr = pidx;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (layer_1_write_complete) state_nxt = S_FETCH;
            S_FETCH: if (k == 2'd3) state_nxt = S_LAST;
            S_LAST:  state_nxt = S_OUT;
            S_OUT: begin
                if (pool_ready) state_nxt = last_win ? S_DONE : S_FETCH;
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: read strobe/address, valid and completion flags
    always_comb begin
        rd_en         = 1'b0;
        rd_addr       = '0;
        pool_valid    = 1'b0;
        pool_complete = 1'b0;
        unique case (state)
            S_FETCH: begin
                rd_en   = 1'b1;
                rd_addr = base + (k[1] ? ROW_OFF : '0)
                        + {{(ADDR_W-1){1'b0}}, k[0]};
            end
            S_OUT:   pool_valid = 1'b1;
            S_DONE:  pool_complete = 1'b1;
            default: ;
        endcase
    end

    // Window counters, fetch sub-count and running max
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k     <= '0;
            c     <= '0;
            r     <= '0;
            base  <= '0;
            pidx  <= '0;
            max_q <= '0;
        end else begin
            if (state == S_FETCH) k <= k + 2'd1;
            if (capture) begin
                if ((state == S_FETCH) && (k == 2'd1)) max_q <= ram_d;
                else if (ram_d > max_q)                max_q <= ram_d;
            end
            if (start) begin
                k    <= '0;
                c    <= '0;
                r    <= '0;
                base <= '0;
                pidx <= '0;
            end else if (accept && !last_win) begin
                pidx <= pidx + 1'b1;
                if (c == C_LAST) begin
                    c    <= '0;
                    r    <= r + 1'b1;
                    base <= base + ROW_STEP;
                end else begin
                    c    <= c + 1'b1;
                    base <= base + COL_STEP;
                end
            end
        end
    end

endmodule
